// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int REGFILE_DATA_W    = 32;
  localparam int REGFILE_DEPTH     = 32;
  localparam int REGFILE_MAX_READ  = 4;
  localparam int REGFILE_IDX_ZERO  = 0;

  // Widest field / bus the extraction helper handles.
  localparam int REGFILE_FIELD_MAX = 64;
  localparam int REGFILE_BUS_MAX   = REGFILE_MAX_READ * REGFILE_FIELD_MAX;

  // Return field k of width w from a bus packed as [k*w +: w], zero-extended.
  function automatic logic [REGFILE_FIELD_MAX-1:0] port_field(
    input logic [REGFILE_BUS_MAX-1:0] bus,
    input int                         k,
    input int                         w
  );
    port_field = '0;
    for (int i = 0; i < REGFILE_FIELD_MAX; i++)
      if (i < w && (k * w + i) < REGFILE_BUS_MAX) port_field[i] = bus[k * w + i];
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by reserve, cleared by
// write. Reserve beats a same-cycle write; index 0 never goes pending.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_READ = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic [ADDR_W-1:0]                  wr_idx,
  input  logic                               rsv_en,
  input  logic [ADDR_W-1:0]                  rsv_idx,
  input  logic [NUM_READ-1:0][ADDR_W-1:0]    rd_idx,
  output logic [NUM_READ-1:0]                rd_pending,
  output logic                               any_pending
);

  logic [DEPTH-1:0] pend;

  // Clear on write, then set on reserve so the later assignment wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend <= '0;
    end else begin
      if (wr_en && wr_idx != ADDR_W'(REGFILE_IDX_ZERO))   pend[wr_idx]  <= 1'b0;
      if (rsv_en && rsv_idx != ADDR_W'(REGFILE_IDX_ZERO)) pend[rsv_idx] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_look
    assign rd_pending[k] = pend[rd_idx[k]];
  end

  assign any_pending = |pend;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with pending-write tracking.
// Register 0 reads as zero. Define REGFILE_BYPASS_EN to forward same-cycle
// write data (and clear the stale pending view) onto matching read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REGFILE_DATA_W,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_READ = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ctrl_writeEnable,
  input  logic [ADDR_W-1:0]            ctrl_writeReg,
  input  logic [DATA_W-1:0]            data_writeReg,
  input  logic                         ctrl_reserve,
  input  logic [ADDR_W-1:0]            ctrl_reserveReg,
  input  logic [NUM_READ*ADDR_W-1:0]   ctrl_readReg,
  output logic [NUM_READ*DATA_W-1:0]   data_readReg,
  output logic [NUM_READ-1:0]          read_pending,
  output logic                         any_pending
);

  logic [DEPTH-1:0][DATA_W-1:0]     mem;
  logic [NUM_READ-1:0][ADDR_W-1:0]  rd_idx;
  logic [NUM_READ-1:0]              sb_pending;
  logic                             wr_ok;

  assign wr_ok = ctrl_writeEnable && (ctrl_writeReg != ADDR_W'(REGFILE_IDX_ZERO));

  // Data array; entry 0 is never written so it holds its reset value of 0.
  always_ff @(posedge clock) begin
    if (reset)      mem <= '0;
    else if (wr_ok) mem[ctrl_writeReg] <= data_writeReg;
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .NUM_READ (NUM_READ)
  ) u_sb (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (ctrl_writeEnable),
    .wr_idx      (ctrl_writeReg),
    .rsv_en      (ctrl_reserve),
    .rsv_idx     (ctrl_reserveReg),
    .rd_idx      (rd_idx),
    .rd_pending  (sb_pending),
    .any_pending (any_pending)
  );

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [DATA_W-1:0] arr_q;

    assign rd_idx[k] = ADDR_W'(port_field(REGFILE_BUS_MAX'(ctrl_readReg), k, ADDR_W));
    assign arr_q     = mem[rd_idx[k]];

`ifdef REGFILE_BYPASS_EN
    logic byp_hit, rsv_hit;
    assign byp_hit = wr_ok && (ctrl_writeReg == rd_idx[k]);
    assign rsv_hit = ctrl_reserve && (ctrl_reserveReg == rd_idx[k]);
    assign data_readReg[k*DATA_W +: DATA_W] = byp_hit ? data_writeReg : arr_q;
    // An in-flight write completes the reservation unless re-reserved now.
    assign read_pending[k] = (byp_hit && !rsv_hit) ? 1'b0 : sb_pending[k];
`else
    assign data_readReg[k*DATA_W +: DATA_W] = arr_q;
    assign read_pending[k] = sb_pending[k];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// array-based reference model. Instance A is 32x32 with 2 ports, instance B
// is 16x32 with 4 ports.
module tb_regfile_mp;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Instance A
  logic             a_we, a_rsv;
  logic [4:0]       a_widx, a_ridx;
  logic [31:0]      a_wd;
  logic [1:0][4:0]  a_rd;
  logic [63:0]      a_q;
  logic [1:0]       a_pend;
  logic             a_any;

  regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_READ(2)) u_a (
    .clock            (clock),
    .reset            (reset),
    .ctrl_writeEnable (a_we),
    .ctrl_writeReg    (a_widx),
    .data_writeReg    (a_wd),
    .ctrl_reserve     (a_rsv),
    .ctrl_reserveReg  (a_ridx),
    .ctrl_readReg     (a_rd),
    .data_readReg     (a_q),
    .read_pending     (a_pend),
    .any_pending      (a_any)
  );

  // Instance B
  logic             b_we;
  logic [3:0]       b_widx;
  logic [31:0]      b_wd;
  logic [3:0][3:0]  b_rd;
  logic [127:0]     b_q;
  logic [3:0]       b_pend;
  logic             b_any;

  regfile_mp #(.DATA_W(32), .DEPTH(16), .NUM_READ(4)) u_b (
    .clock            (clock),
    .reset            (reset),
    .ctrl_writeEnable (b_we),
    .ctrl_writeReg    (b_widx),
    .data_writeReg    (b_wd),
    .ctrl_reserve     (1'b0),
    .ctrl_reserveReg  (4'd0),
    .ctrl_readReg     (b_rd),
    .data_readReg     (b_q),
    .read_pending     (b_pend),
    .any_pending      (b_any)
  );

  // Reference model
  logic [31:0] ma [32];
  bit          mp [32];
  logic [31:0] mb [16];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare A's combinational outputs against the model's view of this cycle.
  task automatic check_a();
    logic [31:0] ed;
    bit          ep, eany;
    int          idx;
    eany = 1'b0;
    for (int i = 0; i < 32; i++) eany |= mp[i];
    for (int k = 0; k < 2; k++) begin
      idx = int'(a_rd[k]);
      ed  = (idx == 0) ? 32'd0 : ma[idx];
      ep  = mp[idx];
`ifdef REGFILE_BYPASS_EN
      if (a_we && a_widx != 0 && int'(a_widx) == idx) begin
        ed = a_wd;
        if (!(a_rsv && int'(a_ridx) == idx)) ep = 1'b0;
      end
`endif
      chk($sformatf("a_data_p%0d_r%0d", k, idx), 64'(a_q[k*32 +: 32]), 64'(ed));
      chk($sformatf("a_pend_p%0d_r%0d", k, idx), 64'(a_pend[k]), 64'(ep));
    end
    chk("a_any", 64'(a_any), 64'(eany));
  endtask

  task automatic drive_a(input logic rst, input logic we, input logic [4:0] widx,
                         input logic [31:0] wd, input logic rsv, input logic [4:0] ridx,
                         input logic [4:0] r0, input logic [4:0] r1);
    @(negedge clock);
    reset = rst; a_we = we; a_widx = widx; a_wd = wd;
    a_rsv = rsv; a_ridx = ridx; a_rd[0] = r0; a_rd[1] = r1;
    b_we = 1'b0;
    #1;
    check_a();
  endtask

  // Advance one edge and apply the register-file rules to the model.
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin ma[i] = '0; mp[i] = 1'b0; end
      for (int i = 0; i < 16; i++) mb[i] = '0;
    end else begin
      if (a_we && a_widx != 0) begin ma[a_widx] = a_wd; mp[a_widx] = 1'b0; end
      if (a_rsv && a_ridx != 0) mp[a_ridx] = 1'b1;
      if (b_we && b_widx != 0) mb[b_widx] = b_wd;
    end
  endtask

  task automatic check_b(input string tag);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = int'(b_rd[k]);
      chk($sformatf("%s_p%0d_r%0d", tag, k, idx), 64'(b_q[k*32 +: 32]),
          64'((idx == 0) ? 32'd0 : mb[idx]));
    end
    chk({tag, "_pend"}, 64'(b_pend), 64'd0);
    chk({tag, "_any"}, 64'(b_any), 64'd0);
  endtask

  initial begin
    logic        we, rsv;
    logic [4:0]  widx, ridx, r0, r1;
    int          base, step;

    reset = 1'b1; a_we = 0; a_widx = 0; a_wd = 0; a_rsv = 0; a_ridx = 0; a_rd = '0;
    b_we = 0; b_widx = 0; b_wd = 0; b_rd = '0;
    for (int i = 0; i < 32; i++) begin ma[i] = '0; mp[i] = 1'b0; end
    for (int i = 0; i < 16; i++) mb[i] = '0;

    // Reset then read
    @(negedge clock); tick();
    drive_a(1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 5);
    chk("rst_r0", 64'(a_q[31:0]), 64'd0);
    chk("rst_r5", 64'(a_q[63:32]), 64'd0);
    chk("rst_pend", 64'(a_pend), 64'd0);
    chk("rst_any", 64'(a_any), 64'd0);
    tick();
    drive_a(0, 0, 0, 0, 0, 0, 31, 31);
    chk("rst_r31", 64'(a_q), 64'd0);
    tick();

    // Write / read, and r0 ignores writes
    drive_a(0, 1, 7, 32'hDEADBEEF, 0, 0, 0, 0); tick();
    drive_a(0, 0, 0, 0, 0, 0, 7, 7);
    chk("r7_p0", 64'(a_q[31:0]), 64'hDEADBEEF);
    chk("r7_p1", 64'(a_q[63:32]), 64'hDEADBEEF);
    tick();
    drive_a(0, 1, 0, 32'h1234, 0, 0, 1, 2); tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_zero", 64'(a_q), 64'd0);
    tick();

    // Scoreboard
    drive_a(0, 0, 0, 0, 1, 9, 0, 0); tick();
    drive_a(0, 0, 0, 0, 0, 0, 9, 9);
    chk("rsv9_pend", 64'(a_pend), 64'd3);
    chk("rsv9_any", 64'(a_any), 64'd1);
    tick();
    drive_a(0, 1, 9, 32'h55, 0, 0, 0, 0); tick();
    drive_a(0, 0, 0, 0, 0, 0, 9, 0);
    chk("wr9_pend", 64'(a_pend[0]), 64'd0);
    chk("wr9_data", 64'(a_q[31:0]), 64'h55);
    chk("wr9_any", 64'(a_any), 64'd0);
    tick();
    drive_a(0, 1, 9, 32'h55, 1, 9, 0, 0); tick();
    drive_a(0, 0, 0, 0, 0, 0, 9, 0);
    chk("wrrsv9_data", 64'(a_q[31:0]), 64'h55);
    chk("wrrsv9_pend", 64'(a_pend[0]), 64'd1);
    tick();

    // Bypass
    drive_a(0, 1, 3, 32'h11, 0, 0, 0, 0); tick();
    drive_a(0, 1, 3, 32'hA5A5A5A5, 0, 0, 0, 3);
`ifdef REGFILE_BYPASS_EN
    chk("byp_same", 64'(a_q[63:32]), 64'hA5A5A5A5);
`else
    chk("byp_old", 64'(a_q[63:32]), 64'h11);
`endif
    tick();
    drive_a(0, 0, 0, 0, 0, 0, 0, 3);
    chk("byp_next", 64'(a_q[63:32]), 64'hA5A5A5A5);
    tick();

    // Reset during a reservation, then an ordinary completion write
    drive_a(0, 0, 0, 0, 1, 12, 0, 0); tick();
    drive_a(1, 1, 12, 32'h77, 0, 0, 12, 12); tick();
    drive_a(0, 0, 0, 0, 0, 0, 12, 9);
    chk("rstmid_data", 64'(a_q[31:0]), 64'd0);
    chk("rstmid_pend", 64'(a_pend), 64'd0);
    chk("rstmid_any", 64'(a_any), 64'd0);
    tick();
    drive_a(0, 1, 12, 32'h77, 0, 0, 0, 0); tick();
    drive_a(0, 0, 0, 0, 0, 0, 12, 0);
    chk("late_wr_data", 64'(a_q[31:0]), 64'h77);
    chk("late_wr_pend", 64'(a_pend[0]), 64'd0);
    tick();

    // Randomized traffic on A
    for (int n = 0; n < 400; n++) begin
      we   = 1'($urandom_range(0, 1));
      widx = 5'($urandom);
      rsv  = ($urandom_range(0, 2) == 0);
      ridx = ($urandom_range(0, 3) == 0) ? widx : 5'($urandom);
      r0   = ($urandom_range(0, 2) == 0) ? widx : 5'($urandom);
      r1   = ($urandom_range(0, 3) == 0) ? ridx : 5'($urandom);
      drive_a(($urandom_range(0, 59) == 0), we, widx, $urandom, rsv, ridx, r0, r1);
      tick();
    end

    // Instance B: fill r1..r15 (plus an ignored r0 write), then 4-way reads
    for (int i = 0; i <= 15; i++) begin
      @(negedge clock);
      reset = 1'b0; a_we = 1'b0; a_rsv = 1'b0;
      b_we = 1'b1; b_widx = 4'(i); b_wd = 32'h1000_0000 + 32'(i * 32'h0101_0101) ^ 32'($urandom_range(0, 255));
      tick();
    end
    @(negedge clock);
    b_we = 1'b0;
    b_rd[0] = 4'd1; b_rd[1] = 4'd5; b_rd[2] = 4'd10; b_rd[3] = 4'd15;
    #1;
    check_b("b_dir");
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      base = int'($urandom_range(0, 15));
      step = 2 * int'($urandom_range(0, 3)) + 1;
      for (int k = 0; k < 4; k++) b_rd[k] = 4'((base + k * step) % 16);
      #1;
      check_b("b_rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
